instr_fetch: RTL and testbench

Instruction fetch unit for the MIPS datapath. It owns the program counter and fetches instruction words from instruction memory over a variable-latency request/response interface. It presents each word, with its `op`/`funct` fields, to the controller and datapath over a valid/ready handshake. When the consumer accepts a word, the unit takes the resolved `Branch`/`Zero`/`Jump` for that word and computes the next PC.

---
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// MIPS instruction fetch unit: owns the PC, fetches over a variable-latency
// request/response port and hands each word to the consumer via valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        VALID
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        capture;
    logic [31:0] p4;
    logic [31:0] br_off;
    logic [31:0] pc_next;

    // Request and valid are pure state decodes, so nothing from the inputs
    // reaches imem_req/imem_addr/instr_valid combinationally.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                imem_req   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        p4     = pc + 32'd4;
        br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (Jump) begin
            pc_next = {p4[31:28], instr[25:0], 2'b00};
        end else if (Branch && Zero) begin
            pc_next = p4 + br_off;
        end else begin
            pc_next = p4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            fetch_count <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                instr <= imem_rdata;
            end
            if (accept) begin
                pc          <= pc_next;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a transaction-level driver/model walks each
// instruction through fetch, response, backpressure and accept.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic [31:0] fetch_count;

    // Second unit starting at the top of the address space, driven in lockstep.
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [31:0] w_pc;
    logic        w_valid;
    logic [31:0] w_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    logic [31:0] ref_pc;
    logic [31:0] ref_cnt;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .instr(instr), .op(op), .funct(funct), .pc(pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Branch(Branch), .Zero(Zero), .Jump(Jump),
        .fetch_count(fetch_count)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .instr(w_instr), .op(w_op), .funct(w_funct), .pc(w_pc),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .Branch(Branch), .Zero(Zero), .Jump(Jump),
        .fetch_count(w_cnt)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the falling edge of the fetch cycle; leaves at the falling
    // edge of the following fetch cycle with the model PC/count advanced.
    task automatic do_instr(input int unsigned lat, input int unsigned bp,
                            input logic br, input logic zr, input logic jp,
                            input logic spur);
        logic [31:0] w;
        logic [31:0] p4;
        int          off;
        w = mem_rd(ref_pc);
        chk("fetch_req", 32'(imem_req), 1);
        chk("fetch_addr", imem_addr, ref_pc);
        chk("fetch_valid", 32'(instr_valid), 0);
        chk("fetch_cnt", fetch_count, ref_cnt);
        imem_rvalid = spur;
        imem_rdata  = $urandom;
        instr_ready = 1'($urandom);
        for (int unsigned i = 1; i <= lat; i++) begin
            cyc();
            chk("wait_req", 32'(imem_req), 0);
            chk("wait_valid", 32'(instr_valid), 0);
            chk("wait_pc", pc, ref_pc);
            chk("wait_cnt", fetch_count, ref_cnt);
            instr_ready = 1'($urandom);
            imem_rvalid = (i == lat);
            imem_rdata  = (i == lat) ? w : $urandom;
        end
        cyc();
        chk("valid_rise", 32'(instr_valid), 1);
        chk("instr", instr, w);
        chk("op", 32'(op), 32'(w[31:26]));
        chk("funct", 32'(funct), 32'(w[5:0]));
        chk("valid_pc", pc, ref_pc);
        chk("valid_req", 32'(imem_req), 0);
        for (int unsigned j = 0; j < bp; j++) begin
            instr_ready = 1'b0;
            imem_rvalid = spur;
            imem_rdata  = $urandom;
            Branch      = 1'($urandom);
            Zero        = 1'($urandom);
            Jump        = 1'($urandom);
            cyc();
            chk("bp_valid", 32'(instr_valid), 1);
            chk("bp_instr", instr, w);
            chk("bp_pc", pc, ref_pc);
            chk("bp_req", 32'(imem_req), 0);
            chk("bp_cnt", fetch_count, ref_cnt);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        Branch      = br;
        Zero        = zr;
        Jump        = jp;
        cyc();
        instr_ready = 1'b0;
        Branch      = 1'b0;
        Zero        = 1'b0;
        Jump        = 1'b0;
        p4 = ref_pc + 32'd4;
        off = $signed(w[15:0]);
        if (jp) ref_pc = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        else if (br && zr) ref_pc = p4 + 32'(off * 4);
        else ref_pc = p4;
        ref_cnt = ref_cnt + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_rdata  = '0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        Branch      = 1'b0;
        Zero        = 1'b0;
        Jump        = 1'b0;
        mem[32'h0000_0000] = 32'h0022_1820;
        mem[32'h0000_0004] = 32'h1000_0003;
        mem[32'h0000_0014] = 32'h0800_0010;
        mem[32'h0000_0040] = 32'h1000_FFFF;
        repeat (2) @(negedge clk);

        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_op", 32'(op), 0);
        chk("rst_funct", 32'(funct), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_cnt", fetch_count, 0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        cyc();
        ref_pc  = 32'h0;
        ref_cnt = 32'h0;
        chk("wrap_first_req", 32'(w_req), 1);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

        do_instr(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("seq_addr", imem_addr, 32'h4);
        chk("wrap_addr", w_addr, 32'h0);
        chk("wrap_cnt", w_cnt, 1);
        do_instr(1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_taken_addr", imem_addr, 32'h14);
        chk("br_taken_cnt", fetch_count, 2);
        do_instr(2, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("jump_addr", imem_addr, 32'h40);
        do_instr(1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("back_br_addr", imem_addr, 32'h40);
        do_instr(4, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_next_addr", imem_addr, 32'h44);

        repeat (40) begin
            do_instr($urandom_range(5, 1), $urandom_range(4, 0),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("rand_addr", imem_addr, ref_pc);
        chk("rand_cnt", fetch_count, ref_cnt);

        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        cyc();
        chk("pre_rst_wait_req", 32'(imem_req), 0);
        chk("pre_rst_wait_pc", pc, ref_pc);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_addr", imem_addr, 0);
        chk("midrst_cnt", fetch_count, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        ref_pc  = 32'h0;
        ref_cnt = 32'h0;
        do_instr(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br_not_taken_addr", imem_addr, 32'h8);
        chk("final_cnt", fetch_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
